// File: rtl/stopwatch_bcd_multi_pkg.sv
// stopwatch_pkg
// Shared types and helpers for the multi-digit BCD stopwatch.
//   bcd_t    : one BCD digit (4 bits)
//   BCD_MAX  : largest legal digit value (9)
//   BCD_MIN  : smallest legal digit value (0)
//   bcd_sat  : clamps an arbitrary nibble into the legal BCD range
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t BCD_MIN = 4'd0;

  // Nibbles above 9 (A..F) are not valid BCD, so they are pinned to 9
  // rather than being allowed into the counter chain.
  function automatic bcd_t bcd_sat(input bcd_t x);
    return (x > BCD_MAX) ? BCD_MAX : x;
  endfunction

endpackage

// File: rtl/stopwatch_bcd_multi_bcd_digit_counter.sv
// bcd_digit_counter
// One BCD digit of the cascaded stopwatch. Counts up or down, wrapping
// 9->0 or 0->9, when enabled by the lower digits.
// Ports:
//   i_clk     : system clock, rising edge
//   i_rst_n   : asynchronous active-low reset
//   i_clr     : synchronous clear to 0 (highest priority)
//   i_ld      : synchronous load of saturated i_ld_val
//   i_ld_val  : preload digit (values above 9 saturate to 9)
//   i_en      : step enable for this digit
//   i_up      : 1 = increment, 0 = decrement
//   o_q       : current digit value
//   o_at_max  : digit equals 9
//   o_at_min  : digit equals 0
module bcd_digit_counter
  import stopwatch_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_ld,
  input  bcd_t i_ld_val,
  input  logic i_en,
  input  logic i_up,
  output bcd_t o_q,
  output logic o_at_max,
  output logic o_at_min
);

  bcd_t q;

  // Digit register: clear beats load beats counting. Wrapping at the
  // ends of the range is what lets the higher digits see a clean carry
  // or borrow on the same edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q <= BCD_MIN;
    end else if (i_clr) begin
      q <= BCD_MIN;
    end else if (i_ld) begin
      q <= bcd_sat(i_ld_val);
    end else if (i_en) begin
      if (i_up) begin
        q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
      end else begin
        q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
      end
    end
  end

  assign o_q      = q;
  assign o_at_max = (q == BCD_MAX);
  assign o_at_min = (q == BCD_MIN);

endmodule

// File: rtl/stopwatch_bcd_multi.sv
// stopwatch_bcd_multi
// Parametrised up/down BCD stopwatch with preload, lap freeze and
// wrap/zero status. Feeds the seven-segment mux through o_disp.
// Parameters:
//   DVSR     : clock cycles per count tick (>= 2)
//   N_DIGITS : number of cascaded BCD digits (1..8), digit 0 is LSD
// Ports:
//   i_clk        : system clock, rising edge
//   i_rst_n      : asynchronous active-low reset
//   i_go         : run enable for the prescaler
//   i_clr        : synchronous clear of count, prescaler and lap state
//   i_up         : count direction, 1 = up
//   i_ld         : synchronous load of i_ld_val into the count
//   i_ld_val     : packed BCD preload value
//   i_lap        : single-cycle pulse that toggles lap freeze
//   o_disp       : frozen lap value while lap is active, else live count
//   o_count      : live count
//   o_lap_active : display is frozen
//   o_wrap       : one-cycle pulse after an up tick rolls all-9s to all-0s
//   o_zero       : live count is all zeros
module stopwatch_bcd_multi
  import stopwatch_pkg::*;
#(
  parameter int DVSR     = 10_000_000,
  parameter int N_DIGITS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_go,
  input  logic                  i_clr,
  input  logic                  i_up,
  input  logic                  i_ld,
  input  logic [4*N_DIGITS-1:0] i_ld_val,
  input  logic                  i_lap,
  output logic [4*N_DIGITS-1:0] o_disp,
  output logic [4*N_DIGITS-1:0] o_count,
  output logic                  o_lap_active,
  output logic                  o_wrap,
  output logic                  o_zero
);

  localparam int            PW   = $clog2(DVSR);
  localparam logic [PW-1:0] PMAX = PW'(DVSR - 1);

  logic [PW-1:0]           presc;
  logic                    tick;
  logic                    tick_en;
  logic                    all_max;
  logic                    all_min;
  logic [N_DIGITS-1:0]     at_max;
  logic [N_DIGITS-1:0]     at_min;
  logic [N_DIGITS-1:0]     en;
  logic [4*N_DIGITS-1:0]   count;
  logic [4*N_DIGITS-1:0]   lap_reg;
  logic                    lap_active;
  logic                    wrap_r;

  // Prescaler: free-runs while i_go is high and restarts on clear or load
  // so a freshly loaded value always gets a full DVSR period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc <= '0;
    end else if (i_clr || i_ld) begin
      presc <= '0;
    end else if (i_go) begin
      presc <= (presc == PMAX) ? '0 : presc + PW'(1);
    end
  end

  assign tick    = i_go && (presc == PMAX);
  assign all_max = &at_max;
  assign all_min = &at_min;

  // A down tick on an all-zero count is swallowed so the chain acts as a
  // countdown timer that parks at zero instead of wrapping to all-9s.
  // Clear and load also take precedence over the tick.
  assign tick_en = tick && !i_clr && !i_ld && !(!i_up && all_min);

  // Each digit steps when every lower digit sits at its rollover value,
  // taken straight from the digit registers so the whole ripple happens
  // in a single tick cycle.
  genvar g;
  generate
    for (g = 0; g < N_DIGITS; g++) begin : g_digit
      if (g == 0) begin : g_lsd
        assign en[g] = tick_en;
      end else begin : g_upper
        assign en[g] = tick_en && (i_up ? (&at_max[g-1:0]) : (&at_min[g-1:0]));
      end

      bcd_digit_counter u_digit (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (i_clr),
        .i_ld     (i_ld),
        .i_ld_val (i_ld_val[4*g +: 4]),
        .i_en     (en[g]),
        .i_up     (i_up),
        .o_q      (count[4*g +: 4]),
        .o_at_max (at_max[g]),
        .o_at_min (at_min[g])
      );
    end
  endgenerate

  // Lap capture: first pulse freezes the pre-tick live count, second pulse
  // releases the display. Clear drops any frozen value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lap_reg    <= '0;
      lap_active <= 1'b0;
    end else if (i_clr) begin
      lap_reg    <= '0;
      lap_active <= 1'b0;
    end else if (i_lap) begin
      if (!lap_active) begin
        lap_reg    <= count;
        lap_active <= 1'b1;
      end else begin
        lap_active <= 1'b0;
      end
    end
  end

  // Wrap flag is registered, so it lines up with the cycle in which the
  // rolled-over all-zero count first appears.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wrap_r <= 1'b0;
    end else begin
      wrap_r <= tick_en && i_up && all_max;
    end
  end

  assign o_count      = count;
  assign o_disp       = lap_active ? lap_reg : count;
  assign o_lap_active = lap_active;
  assign o_wrap       = wrap_r;
  assign o_zero       = all_min;

endmodule

// File: tb/tb_stopwatch_bcd_multi.sv
// tb_stopwatch_bcd_multi
// Directed bench for stopwatch_bcd_multi with DVSR=4, N_DIGITS=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_stopwatch_bcd_multi;

  localparam int DVSR     = 4;
  localparam int N_DIGITS = 3;
  localparam int W        = 4 * N_DIGITS;

  logic         clk;
  logic         rst_n;
  logic         go;
  logic         clr;
  logic         up;
  logic         ld;
  logic [W-1:0] ld_val;
  logic         lap;
  logic [W-1:0] disp;
  logic [W-1:0] count;
  logic         lap_active;
  logic         wrap;
  logic         zero;

  int n_checks;
  int n_pass;
  bit wrap_seen;

  stopwatch_bcd_multi #(
    .DVSR     (DVSR),
    .N_DIGITS (N_DIGITS)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_go         (go),
    .i_clr        (clr),
    .i_up         (up),
    .i_ld         (ld),
    .i_ld_val     (ld_val),
    .i_lap        (lap),
    .o_disp       (disp),
    .o_count      (count),
    .o_lap_active (lap_active),
    .o_wrap       (wrap),
    .o_zero       (zero)
  );

  // 10-unit clock period, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives every control input in one call so each directed step is explicit.
  task automatic applyStimulus(input logic s_go, input logic s_clr, input logic s_up,
                               input logic s_ld, input logic [W-1:0] s_ld_val,
                               input logic s_lap);
    go     = s_go;
    clr    = s_clr;
    up     = s_up;
    ld     = s_ld;
    ld_val = s_ld_val;
    lap    = s_lap;
  endtask

  // One comparison; failures are counted and reported, then the run goes on.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) begin
      n_pass++;
    end else begin
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advances n full cycles, ending on a falling edge, and records any wrap pulse.
  task automatic stepCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      if (wrap === 1'b1) wrap_seen = 1'b1;
    end
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    wrap_seen = 1'b0;
    rst_n     = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);

    // Reset values
    @(negedge clk);
    checkOutput("reset_count", 32'(count), 32'h000);
    checkOutput("reset_disp", 32'(disp), 32'h000);
    checkOutput("reset_zero", 32'(zero), 32'h1);
    checkOutput("reset_lap", 32'(lap_active), 32'h0);
    checkOutput("reset_wrap", 32'(wrap), 32'h0);

    // Step 1: 40 cycles counting up -> 10 ticks
    $display("[TB] step 1: free count up");
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    stepCycles(40);
    checkOutput("s1_count", 32'(count), 32'h010);
    checkOutput("s1_zero", 32'(zero), 32'h0);
    checkOutput("s1_no_wrap", 32'(wrap_seen), 32'h0);

    // Step 2: rollover from 0x998
    $display("[TB] step 2: up rollover");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 12'h998, 1'b0);
    stepCycles(1);
    checkOutput("s2_load", 32'(count), 32'h998);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    stepCycles(4);
    checkOutput("s2_count_999", 32'(count), 32'h999);
    checkOutput("s2_wrap_low", 32'(wrap), 32'h0);
    stepCycles(3);
    checkOutput("s2_count_hold", 32'(count), 32'h999);
    checkOutput("s2_wrap_pre", 32'(wrap), 32'h0);
    stepCycles(1);
    checkOutput("s2_count_000", 32'(count), 32'h000);
    checkOutput("s2_wrap_pulse", 32'(wrap), 32'h1);
    checkOutput("s2_zero", 32'(zero), 32'h1);
    stepCycles(1);
    checkOutput("s2_wrap_one_cycle", 32'(wrap), 32'h0);

    // Step 3: count down from 0x002 and park at zero
    $display("[TB] step 3: countdown stops at zero");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 12'h002, 1'b0);
    stepCycles(1);
    wrap_seen = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    stepCycles(4);
    checkOutput("s3_count_001", 32'(count), 32'h001);
    checkOutput("s3_zero_low", 32'(zero), 32'h0);
    stepCycles(4);
    checkOutput("s3_count_000", 32'(count), 32'h000);
    stepCycles(12);
    checkOutput("s3_count_hold", 32'(count), 32'h000);
    checkOutput("s3_zero", 32'(zero), 32'h1);
    checkOutput("s3_no_wrap", 32'(wrap_seen), 32'h0);

    // Step 4: lap freeze
    $display("[TB] step 4: lap freeze");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    stepCycles(1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    stepCycles(20);
    checkOutput("s4_count_005", 32'(count), 32'h005);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    stepCycles(1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    stepCycles(12);
    checkOutput("s4_disp_frozen", 32'(disp), 32'h005);
    checkOutput("s4_count_live", 32'(count), 32'h008);
    checkOutput("s4_lap_active", 32'(lap_active), 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    stepCycles(1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    checkOutput("s4_disp_released", 32'(disp), 32'h008);
    checkOutput("s4_lap_off", 32'(lap_active), 32'h0);

    // Step 5: saturation on load, then clear beats load
    $display("[TB] step 5: load saturation and clear priority");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 12'hA3F, 1'b0);
    stepCycles(1);
    checkOutput("s5_saturate", 32'(count), 32'h939);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 12'h555, 1'b1);
    stepCycles(1);
    checkOutput("s5_clr_over_ld", 32'(count), 32'h000);
    checkOutput("s5_clr_over_lap", 32'(lap_active), 32'h0);
    checkOutput("s5_zero", 32'(zero), 32'h1);

    // Step 6: asynchronous reset mid-count with lap active
    $display("[TB] step 6: async reset");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 12'h123, 1'b0);
    stepCycles(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    stepCycles(1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    stepCycles(2);
    checkOutput("s6_pre_count", 32'(count), 32'h123);
    checkOutput("s6_pre_lap", 32'(lap_active), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("s6_rst_count", 32'(count), 32'h000);
    checkOutput("s6_rst_disp", 32'(disp), 32'h000);
    checkOutput("s6_rst_lap", 32'(lap_active), 32'h0);
    checkOutput("s6_rst_wrap", 32'(wrap), 32'h0);
    checkOutput("s6_rst_zero", 32'(zero), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    stepCycles(3);
    checkOutput("s6_no_early_tick", 32'(count), 32'h000);
    stepCycles(1);
    checkOutput("s6_first_tick", 32'(count), 32'h001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
